// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// The zero-fill sweep is enabled by defining MEM_ARB_CLR_EN.
package mem_arb_pkg;
    localparam int AW_DEF    = 15;
    localparam int DW_DEF    = 16;
    localparam int MEM_DEPTH = 1 << AW_DEF;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_clr_seq.sv
// Address counter for the post-reset zero-fill sweep; done_o is high on the last address.
// Only instantiated when MEM_ARB_CLR_EN is defined.
module mem_clr_seq
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [AW-1:0] cnt_o,
    output logic          done_o
);
    logic [AW-1:0] cnt_q, cnt_d;

    assign done_o = &cnt_q;
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !done_o) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin sequencer in front of a single-port async-read memory.
// Define MEM_ARB_CLR_EN to add the post-reset zero-fill sweep (busy high while it runs).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo,
    output arb_state_e    dbg_state_o
);
    // Handshake: reqN rises and stays high until the cycle ackN=1; we/addr/wdata
    // are sampled on the grant edge only, ackN is a single-cycle pulse.
    arb_state_e    state_q, state_d;
    logic          gnt_q, gnt_d, last_q, last_d;
    logic          grant, win, other;
    logic [AW-1:0] mem_a_q, mem_a_d, clr_cnt;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          mem_we_q, mem_we_d, clr_done;

`ifdef MEM_ARB_CLR_EN
    localparam arb_state_e RST_STATE = ST_CLEAR;

    mem_clr_seq #(.AW(AW)) u_clr_seq (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (state_q == ST_CLEAR),
        .cnt_o  (clr_cnt),
        .done_o (clr_done)
    );
`else
    localparam arb_state_e RST_STATE = ST_IDLE;

    assign clr_cnt  = '0;
    assign clr_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = gnt_q;
        other   = ~gnt_q;
        case (state_q)
            ST_CLEAR:  if (clr_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    win     = (req0 && req1) ? ~last_q : req1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_ACK;
            ST_ACK: begin
                // The port just acked is masked; only the other one may chain in.
                if (other ? req1 : req0) begin
                    grant   = 1'b1;
                    win     = other;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        ack0 = (state_q == ST_ACK) && !gnt_q;
        ack1 = (state_q == ST_ACK) && gnt_q;
`ifdef MEM_ARB_CLR_EN
        busy = (state_q == ST_CLEAR);
`else
        busy = 1'b0;
`endif
    end

    always_comb begin
        gnt_d    = gnt_q;
        last_d   = last_q;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == ST_CLEAR) begin
            mem_we_d = 1'b1;
            mem_a_d  = clr_cnt;
            mem_d_d  = '0;
        end
        if (grant) begin
            gnt_d    = win;
            last_d   = win;
            mem_we_d = win ? we1 : we0;
            mem_a_d  = win ? addr1 : addr0;
            mem_d_d  = win ? wdata1 : wdata0;
        end
        if (state_q == ST_ACCESS && !mem_we_q) begin
            if (gnt_q) rdata1_d = mem_spo;
            else       rdata0_d = mem_spo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_a       = mem_a_q;
    assign mem_d       = mem_d_q;
    assign mem_we      = mem_we_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses, a transaction-level model checked every cycle.
// Define MEM_ARB_CLR_EN to also exercise the zero-fill sweep.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = AW_DEF;
    localparam int DW    = DW_DEF;
    localparam int DEPTH = MEM_DEPTH;
`ifdef MEM_ARB_CLR_EN
    localparam logic [DW-1:0] INIT     = 16'hFFFF;
    localparam logic          RST_BUSY = 1'b1;
`else
    localparam logic [DW-1:0] INIT     = 16'h0000;
    localparam logic          RST_BUSY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_v, we_v;
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wdata_v [2];
    logic          ack0, ack1, busy, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_d, mem_spo;
    logic [AW-1:0] mem_a;
    arb_state_e    dbg_state;

    logic [DW-1:0] mem_arr [0:DEPTH-1];
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            ack_port_q[$];
    int            ack_cyc_q[$];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .req1(req_v[1]),
        .we0(we_v[0]), .we1(we_v[1]),
        .addr0(addr_v[0]), .addr1(addr_v[1]),
        .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
        .dbg_state_o(dbg_state)
    );

    // Clock, cycle counter and the mem32k stand-in
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_we) mem_arr[mem_a] = mem_d;
    assign mem_spo = mem_arr[mem_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: at most one transaction in flight; phase 1 = memory cycle, phase 2 = ack cycle.
    int            m_phase, m_port, m_last, m_c, busy_cnt;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd [2];
    logic          clearing, clr_wr, exp_we;
    logic [1:0]    exp_ack;
    int            w;

    task automatic model_grant(input int p);
        m_port  = p;
        m_last  = p;
        m_we    = we_v[p];
        m_addr  = addr_v[p];
        m_wd    = wdata_v[p];
        m_phase = 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_last = 1; m_c = 0; busy_cnt = 0;
            m_rd[0] = '0; m_rd[1] = '0;
            chk("rst_ack0", 32'(ack0), 0);
            chk("rst_ack1", 32'(ack1), 0);
            chk("rst_rdata0", 32'(rdata0), 0);
            chk("rst_rdata1", 32'(rdata1), 0);
            chk("rst_mem_a", 32'(mem_a), 0);
            chk("rst_mem_d", 32'(mem_d), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_busy", 32'(busy), 32'(RST_BUSY));
        end else begin
`ifdef MEM_ARB_CLR_EN
            clearing = (m_c < DEPTH);
            clr_wr   = (m_c >= 1) && (m_c <= DEPTH);
`else
            clearing = 1'b0;
            clr_wr   = 1'b0;
`endif
            exp_ack = 2'b00;
            if (m_phase == 2) exp_ack[m_port] = 1'b1;
            exp_we = clr_wr || (m_phase == 1 && m_we);
            if (busy) busy_cnt++;
            chk("busy", 32'(busy), 32'(clearing));
            chk("ack0", 32'(ack0), 32'(exp_ack[0]));
            chk("ack1", 32'(ack1), 32'(exp_ack[1]));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
            chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
            if (clr_wr) begin
                chk("clr_mem_a", 32'(mem_a), 32'(m_c - 1));
                chk("clr_mem_d", 32'(mem_d), 0);
            end else if (m_phase == 1) begin
                chk("mem_a", 32'(mem_a), 32'(m_addr));
                if (m_we) chk("mem_d", 32'(mem_d), 32'(m_wd));
            end
            // What the coming edge does
            if (clr_wr) exp_mem[m_c - 1] = '0;
            if (m_c <= DEPTH) m_c++;
            if (m_phase == 1) begin
                if (m_we) exp_mem[m_addr] = m_wd;
                else      m_rd[m_port] = exp_mem[m_addr];
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (req_v[1 - m_port]) model_grant(1 - m_port);
                else                   m_phase = 0;
            end else if (!clearing && req_v != 2'b00) begin
                w = (req_v == 2'b11) ? (1 - m_last) : (req_v[0] ? 0 : 1);
                model_grant(w);
            end
        end
    end

    // Driver: one access on port p; keep=1 leaves req high for a chained access
    task automatic access(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit keep, input int budget,
                          output int lat, output logic [DW-1:0] rd);
        int t0;
        bit got;
        we_v[p] = wr; addr_v[p] = a; wdata_v[p] = d; req_v[p] = 1'b1;
        t0 = cyc; got = 0; rd = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) begin
                got = 1;
                rd  = (p == 0) ? rdata0 : rdata1;
                ack_port_q.push_back(p);
                ack_cyc_q.push_back(cyc);
            end
        end
        lat = cyc - t0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL ack_timeout: port %0d no ack within %0d cycles", p, budget);
        end
        @(posedge clk); #1;
        if (!keep) req_v[p] = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40000 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL busy_timeout: busy still high");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1;
        logic [DW-1:0] rd, rd0, rd1, old;
        req_v = '0; we_v = '0;
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = INIT;
            exp_mem[i] = INIT;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef MEM_ARB_CLR_EN
        // Request held through the sweep; reads the freshly cleared top word
        access(1, 1'b0, 15'h7FFF, '0, 1'b0, 40000, lat, rd);
        chk("clr_latency", 32'(lat), 32770);
        chk("clr_rdata1", 32'(rd), 16'h0000);
        chk("clr_busy_cycles", 32'(busy_cnt), 32768);
`endif

        // Simultaneous requests: port 0 wins the first tie
        mem_arr[15'h0010] = 16'hAAAA; exp_mem[15'h0010] = 16'hAAAA;
        mem_arr[15'h7FFF] = 16'h5555; exp_mem[15'h7FFF] = 16'h5555;
        fork
            access(0, 1'b0, 15'h0010, '0, 1'b0, 50, lat0, rd0);
            access(1, 1'b0, 15'h7FFF, '0, 1'b0, 50, lat1, rd1);
        join
        chk("tie_lat0", 32'(lat0), 2);
        chk("tie_lat1", 32'(lat1), 4);
        chk("tie_rdata0", 32'(rd0), 16'hAAAA);
        chk("tie_rdata1", 32'(rd1), 16'h5555);

        // Single-port write then read back
        access(0, 1'b1, 15'h0005, 16'h1234, 1'b0, 50, lat, rd);
        chk("wr_latency", 32'(lat), 2);
        access(0, 1'b0, 15'h0005, '0, 1'b0, 50, lat, rd);
        chk("rd_latency", 32'(lat), 2);
        chk("rd_data", 32'(rd), 16'h1234);

        // Same port back-to-back: 3 cycles per access
        ack_cyc_q.delete(); ack_port_q.delete();
        access(1, 1'b1, 15'h0040, 16'h0040, 1'b1, 50, lat, rd);
        access(1, 1'b0, 15'h0040, '0, 1'b0, 50, lat, rd);
        chk("b2b_gap", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 3);
        chk("b2b_rdata", 32'(rd), 16'h0040);

        // Both ports saturated: strict alternation, one ack every 2 cycles
        ack_cyc_q.delete(); ack_port_q.delete();
        fork
            begin : port0_stream
                int l; logic [DW-1:0] r;
                for (int i = 0; i < 8; i++)
                    access(0, 1'b1, AW'(16'h0200 + i), DW'(16'h0A00 + i), i < 7, 50, l, r);
            end
            begin : port1_stream
                int l; logic [DW-1:0] r;
                for (int i = 0; i < 8; i++) begin
                    access(1, 1'b0, AW'(16'h0200 + i), '0, i < 7, 50, l, r);
                    chk("rr_rdata1", 32'(r), 32'(16'h0A00 + i));
                end
            end
        join
        chk("rr_count", 32'(ack_port_q.size()), 16);
        for (int j = 0; j < ack_port_q.size(); j++) begin
            chk("rr_order", 32'(ack_port_q[j]), 32'(j % 2));
            if (j > 0) chk("rr_gap", 32'(ack_cyc_q[j] - ack_cyc_q[j-1]), 2);
        end

        // Reset while a port 1 write is in its memory cycle
        old = exp_mem[15'h0300];
        we_v[1] = 1'b1; addr_v[1] = 15'h0300; wdata_v[1] = 16'hBEEF; req_v[1] = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_access", 32'(dbg_state), 32'(ST_ACCESS));
        rst_n = 1'b0; req_v[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_write", 32'(mem_arr[15'h0300]), 32'(old));
        rst_n = 1'b1;
        wait_ready();
        access(1, 1'b1, 15'h0300, 16'hBEEF, 1'b0, 50, lat, rd);
        chk("post_rst_wr_lat", 32'(lat), 2);
        access(1, 1'b0, 15'h0300, '0, 1'b0, 50, lat, rd);
        chk("post_rst_rd_lat", 32'(lat), 2);
        chk("post_rst_rdata", 32'(rd), 16'hBEEF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
